alien_fleet_ctrl: RTL and testbench

ALIEN_FLEET_CTRL -- requirements
Module: alien_fleet_ctrl

---
 rtl/alien_fleet_ctrl.sv | 171 +++++++++++++++++
 tb/tb_alien_fleet_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_fleet_ctrl.sv
// Fleet controller: marches the alien fleet side to side, steps it down at edges,
// and respawns the wave after a clear delay. Define FLEET_SPEEDUP_EN to speed the fleet up as aliens die.
module alien_fleet_ctrl #(
    parameter int N_ALIENS     = 8,
    parameter int BASE_SPEED   = 30,
    parameter int MIN_SPEED    = 4,
    parameter int SPEEDUP      = 3,
    parameter int CLEAR_FRAMES = 60,
    parameter int BASE_SHOOT   = 600,
    parameter int SHOOT_STEP   = 50,
    parameter int MIN_SHOOT    = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic [9:0]          xCoord,
    input  logic [9:0]          yCoord,
    input  logic [N_ALIENS-1:0] alive,
    input  logic [N_ALIENS-1:0] is_edge,
    output logic                move_left,
    output logic                move_right,
    output logic                move_down,
    output logic [8:0]          alien_speed,
    output logic [11:0]         shoot_timer,
    output logic                alien_rst,
    output logic [3:0]          level
);

    typedef enum logic [2:0] {IDLE, RIGHT, DOWN_R, LEFT, DOWN_L, CLEAR} state_e;

    localparam int CLR_W = $clog2(CLEAR_FRAMES + 1);

    state_e           state_q, state_d;
    logic [8:0]       stepCnt_q, stepCnt_d;
    logic [CLR_W-1:0] clearCnt_q, clearCnt_d;
    logic             holdoff_q, holdoff_d;
    logic             alienRst_q, alienRst_d;
    logic [3:0]       level_q, level_d;
    logic             moveLeft_q, moveRight_q, moveDown_q;
    logic [11:0]      shootTimer_q;

    logic frameTick, stepEvent, anyEdge, waveClear;

    function automatic logic [11:0] shootFor(input logic [3:0] lvl);
        int v;
        v = BASE_SHOOT - SHOOT_STEP * int'(lvl);
        return (v < MIN_SHOOT) ? 12'(MIN_SHOOT) : 12'(v);
    endfunction

    // The step counter mirrors the one inside each alien, so the down-step lasts exactly one alien step.
    assign frameTick = (xCoord == 10'd0) && (yCoord == 10'd0);
    assign stepEvent = frameTick && !alienRst_q && (stepCnt_q >= alien_speed);
    assign anyEdge   = |(is_edge & alive);
    assign waveClear = frameTick && (alive == '0) && !holdoff_q;

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        clearCnt_d = clearCnt_q;
        holdoff_d  = holdoff_q;
        alienRst_d = 1'b0;
        stepCnt_d  = stepCnt_q;

        if (frameTick) begin
            stepCnt_d = stepEvent ? 9'd0 : stepCnt_q + 9'd1;
            holdoff_d = 1'b0;
        end
        if (alienRst_q) begin
            stepCnt_d = 9'd0;
        end

        case (state_q)
            IDLE: state_d = RIGHT;
            RIGHT, DOWN_R, LEFT, DOWN_L: begin
                if (waveClear) begin
                    state_d    = CLEAR;
                    clearCnt_d = '0;
                end else if (state_q == RIGHT && anyEdge) begin
                    state_d = DOWN_R;
                end else if (state_q == LEFT && anyEdge) begin
                    state_d = DOWN_L;
                end else if (state_q == DOWN_R && stepEvent) begin
                    state_d = LEFT;
                end else if (state_q == DOWN_L && stepEvent) begin
                    state_d = RIGHT;
                end
            end
            CLEAR: begin
                if (frameTick) begin
                    if (clearCnt_q == CLR_W'(CLEAR_FRAMES - 1)) begin
                        state_d    = RIGHT;
                        clearCnt_d = '0;
                        alienRst_d = 1'b1;
                        holdoff_d  = 1'b1;
                        level_d    = (level_q == 4'd15) ? level_q : level_q + 4'd1;
                    end else begin
                        clearCnt_d = clearCnt_q + CLR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!mode) begin
            state_d    = IDLE;
            level_d    = 4'd0;
            stepCnt_d  = 9'd0;
            clearCnt_d = '0;
            holdoff_d  = 1'b0;
            alienRst_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            level_q      <= 4'd0;
            stepCnt_q    <= 9'd0;
            clearCnt_q   <= '0;
            holdoff_q    <= 1'b0;
            alienRst_q   <= 1'b0;
            moveLeft_q   <= 1'b0;
            moveRight_q  <= 1'b0;
            moveDown_q   <= 1'b0;
            shootTimer_q <= 12'(BASE_SHOOT);
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            stepCnt_q    <= stepCnt_d;
            clearCnt_q   <= clearCnt_d;
            holdoff_q    <= holdoff_d;
            alienRst_q   <= alienRst_d;
            moveLeft_q   <= (state_d == LEFT);
            moveRight_q  <= (state_d == RIGHT);
            moveDown_q   <= (state_d == DOWN_R) || (state_d == DOWN_L);
            shootTimer_q <= shootFor(level_q);
        end
    end

`ifdef FLEET_SPEEDUP_EN
    logic [8:0] speed_q;

    function automatic logic [8:0] speedFor(input logic [N_ALIENS-1:0] a);
        int killed;
        int v;
        killed = N_ALIENS - $countones(a);
        v = BASE_SPEED - SPEEDUP * killed;
        return (v < MIN_SPEED) ? 9'(MIN_SPEED) : 9'(v);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            speed_q <= 9'(BASE_SPEED);
        end else begin
            speed_q <= speedFor(alive);
        end
    end

    assign alien_speed = speed_q;
`else
    assign alien_speed = 9'(BASE_SPEED);
`endif

    assign move_left   = moveLeft_q;
    assign move_right  = moveRight_q;
    assign move_down   = moveDown_q;
    assign alien_rst   = alienRst_q;
    assign level       = level_q;
    assign shoot_timer = shootTimer_q;

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Self-checking bench for alien_fleet_ctrl: directed vector table, hand-written
// corner sequences and randomized stimulus against a behavioural fleet model.
module tb_alien_fleet_ctrl;

    localparam int BASE_SPEED   = 30;
    localparam int MIN_SPEED    = 4;
    localparam int SPEEDUP      = 3;
    localparam int CLEAR_FRAMES = 60;
    localparam int BASE_SHOOT   = 600;
    localparam int SHOOT_STEP   = 50;
    localparam int MIN_SHOOT    = 100;

    logic        clk = 1'b0;
    logic        rst, mode;
    logic [9:0]  xCoord, yCoord;
    logic [7:0]  alive, is_edge;
    logic        move_left, move_right, move_down, alien_rst;
    logic [8:0]  alien_speed;
    logic [11:0] shoot_timer;
    logic [3:0]  level;

    alien_fleet_ctrl dut (
        .clk(clk), .rst(rst), .mode(mode), .xCoord(xCoord), .yCoord(yCoord),
        .alive(alive), .is_edge(is_edge), .move_left(move_left), .move_right(move_right),
        .move_down(move_down), .alien_speed(alien_speed), .shoot_timer(shoot_timer),
        .alien_rst(alien_rst), .level(level)
    );

    always #5 clk = ~clk;

    int numCompared = 0;
    int numMismatched = 0;

    // Behavioural model: the fleet is either in the menu, marching sideways,
    // descending one step, or waiting out a wave clear.
    typedef enum {MENU, MARCH, DESCEND, WAITING} phase_e;
    phase_e mPhase = MENU;
    int mDir = 1;
    int mLevel = 0, mSpeed = BASE_SPEED, mShoot = BASE_SHOOT;
    int mTicks = 0, mClearTicks = 0;
    bit mHoldoff = 0, mPulse = 0;

    bit       curMode = 0;
    bit [7:0] curAlive = 8'hFF, curEdge = 8'h00;

    function automatic int shootFor(int lvl);
        int v = BASE_SHOOT - SHOOT_STEP * lvl;
        return (v < MIN_SHOOT) ? MIN_SHOOT : v;
    endfunction

    function automatic int speedFor(bit [7:0] a);
`ifdef FLEET_SPEEDUP_EN
        int v = BASE_SPEED - SPEEDUP * (8 - $countones(a));
        return (v < MIN_SPEED) ? MIN_SPEED : v;
`else
        return BASE_SPEED + 0 * a;
`endif
    endfunction

    task automatic modelStep(input bit r, input bit m, input bit [9:0] x, input bit [9:0] y,
                             input bit [7:0] a, input bit [7:0] e);
        bit tick, stepNow, guard, oldPulse;
        int oldSpeed;
        tick = (x == 0) && (y == 0);
        if (r) begin
            mPhase = MENU; mDir = 1; mLevel = 0; mSpeed = BASE_SPEED; mShoot = BASE_SHOOT;
            mTicks = 0; mClearTicks = 0; mHoldoff = 0; mPulse = 0;
            return;
        end
        oldSpeed = mSpeed;
        oldPulse = mPulse;
        mShoot = shootFor(mLevel);
        mSpeed = speedFor(a);
        mPulse = 0;
        if (!m) begin
            mPhase = MENU; mLevel = 0; mTicks = 0; mClearTicks = 0; mHoldoff = 0;
            return;
        end
        stepNow = tick && !oldPulse && (mTicks >= oldSpeed);
        if (oldPulse) mTicks = 0;
        else if (tick) mTicks = stepNow ? 0 : mTicks + 1;
        guard = mHoldoff;
        if (tick) mHoldoff = 0;
        case (mPhase)
            MENU: begin mPhase = MARCH; mDir = 1; end
            MARCH, DESCEND: begin
                if (tick && a == 0 && !guard) begin
                    mPhase = WAITING; mClearTicks = 0;
                end else if (mPhase == MARCH && (e & a) != 0) begin
                    mPhase = DESCEND;
                end else if (mPhase == DESCEND && stepNow) begin
                    mPhase = MARCH; mDir = -mDir;
                end
            end
            WAITING: if (tick) begin
                mClearTicks++;
                if (mClearTicks == CLEAR_FRAMES) begin
                    mPhase = MARCH; mDir = 1; mPulse = 1; mHoldoff = 1; mClearTicks = 0;
                    mLevel = (mLevel >= 15) ? 15 : mLevel + 1;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input bit r, input bit m, input bit [9:0] x, input bit [9:0] y,
                                 input bit [7:0] a, input bit [7:0] e);
        rst = r; mode = m; xCoord = x; yCoord = y; alive = a; is_edge = e;
        modelStep(r, m, x, y, a, e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
        numCompared++;
        if (act !== 32'(exp)) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("move_right", 32'(move_right), (mPhase == MARCH && mDir > 0) ? 1 : 0);
        checkOutput("move_left", 32'(move_left), (mPhase == MARCH && mDir < 0) ? 1 : 0);
        checkOutput("move_down", 32'(move_down), (mPhase == DESCEND) ? 1 : 0);
        checkOutput("alien_rst", 32'(alien_rst), mPulse ? 1 : 0);
        checkOutput("level", 32'(level), mLevel);
        checkOutput("alien_speed", 32'(alien_speed), mSpeed);
        checkOutput("shoot_timer", 32'(shoot_timer), mShoot);
    endtask

    task automatic tickCycle();
        applyStimulus(1'b0, curMode, 10'd0, 10'd0, curAlive, curEdge);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, curMode, 10'd7, 10'd3, curAlive, curEdge);
    endtask

    task automatic runClear(input bit checkEach);
        bit sawPulse = 0;
        for (int i = 0; i < 300 && !sawPulse; i++) begin
            tickCycle();
            if (checkEach) checkAll();
            if (alien_rst) sawPulse = 1;
            else begin
                idleCycle();
                if (checkEach) checkAll();
            end
        end
        checkOutput("respawn_pulse_seen", 32'(sawPulse), 1);
    endtask

    typedef struct {
        bit       r;
        bit       m;
        bit [7:0] a;
        bit [7:0] e;
        bit       expR;
        bit       expL;
        bit       expD;
        int       expShoot;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 600};
        vecs[1] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 600};
        vecs[2] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 600};
        vecs[3] = '{1'b0, 1'b1, 8'hDF, 8'h20, 1'b1, 1'b0, 1'b0, 600};
        vecs[4] = '{1'b0, 1'b1, 8'hFF, 8'h08, 1'b0, 1'b0, 1'b1, 600};
        vecs[5] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 600};
        vecs[6] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 600};
        vecs[7] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 600};

        rst = 1'b1; mode = 1'b0; xCoord = 10'd7; yCoord = 10'd3; alive = 8'hFF; is_edge = 8'h00;

        // Vector table: reset, start-up, dead-alien edge ignored, edge descent, menu return.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].r, vecs[i].m, 10'd7, 10'd3, vecs[i].a, vecs[i].e);
            checkOutput($sformatf("vec%0d_right", i), 32'(move_right), int'(vecs[i].expR));
            checkOutput($sformatf("vec%0d_left", i), 32'(move_left), int'(vecs[i].expL));
            checkOutput($sformatf("vec%0d_down", i), 32'(move_down), int'(vecs[i].expD));
            checkOutput($sformatf("vec%0d_shoot", i), 32'(shoot_timer), vecs[i].expShoot);
        end
        checkOutput("reset_speed", 32'(alien_speed), 30);
        checkOutput("reset_level", 32'(level), 0);

        // Edge descent lasts one alien step: 31 frame ticks from a fresh counter.
        curMode = 1; curAlive = 8'hFF; curEdge = 8'h00;
        applyStimulus(1'b1, 1'b0, 10'd7, 10'd3, curAlive, curEdge);
        idleCycle();
        curEdge = 8'h08; idleCycle(); curEdge = 8'h00;
        checkOutput("edge_down", 32'(move_down), 1);
        for (int i = 0; i < 30; i++) begin tickCycle(); idleCycle(); end
        checkOutput("down_held_30", 32'(move_down), 1);
        checkOutput("left_not_yet", 32'(move_left), 0);
        tickCycle();
        checkOutput("down_released", 32'(move_down), 0);
        checkOutput("left_after_step", 32'(move_left), 1);

        // Fleet speed against the number of survivors.
        curAlive = 8'h0F; idleCycle(); idleCycle();
`ifdef FLEET_SPEEDUP_EN
        checkOutput("speed_4_alive", 32'(alien_speed), 18);
`else
        checkOutput("speed_4_alive", 32'(alien_speed), 30);
`endif
        curAlive = 8'h01; idleCycle();
`ifdef FLEET_SPEEDUP_EN
        checkOutput("speed_1_alive", 32'(alien_speed), 9);
`else
        checkOutput("speed_1_alive", 32'(alien_speed), 30);
`endif

        // Wave clear, respawn timing and holdoff.
        curAlive = 8'h00; tickCycle();
        checkOutput("clear_left", 32'(move_left), 0);
        checkOutput("clear_right", 32'(move_right), 0);
        checkOutput("clear_down", 32'(move_down), 0);
        idleCycle();
        for (int i = 0; i < 59; i++) begin tickCycle(); idleCycle(); end
        checkOutput("no_early_respawn", 32'(alien_rst), 0);
        checkOutput("still_clearing", 32'(move_right), 0);
        tickCycle();
        checkOutput("respawn_pulse", 32'(alien_rst), 1);
        checkOutput("respawn_level", 32'(level), 1);
        checkOutput("respawn_right", 32'(move_right), 1);
        idleCycle();
        checkOutput("pulse_one_cycle", 32'(alien_rst), 0);
        checkOutput("shoot_level1", 32'(shoot_timer), 550);
        tickCycle();
        checkOutput("holdoff_right", 32'(move_right), 1);
        idleCycle();
        checkAll();

        // Climb to level 3, descend from the left march, then drop to the menu.
        runClear(1'b0);
        runClear(1'b0);
        checkOutput("level3", 32'(level), 3);
        curAlive = 8'hFF;
        idleCycle();
        curEdge = 8'h08; idleCycle(); curEdge = 8'h00;
        begin
            bit gotLeft = 0;
            for (int i = 0; i < 100 && !gotLeft; i++) begin
                tickCycle();
                if (move_left) gotLeft = 1; else idleCycle();
            end
            checkOutput("reach_left", 32'(gotLeft), 1);
        end
        curEdge = 8'h01; idleCycle(); curEdge = 8'h00;
        checkOutput("downl_down", 32'(move_down), 1);
        checkOutput("downl_shoot", 32'(shoot_timer), 450);
        curMode = 0; idleCycle();
        checkOutput("menu_right", 32'(move_right), 0);
        checkOutput("menu_left", 32'(move_left), 0);
        checkOutput("menu_down", 32'(move_down), 0);
        checkOutput("menu_level", 32'(level), 0);
        idleCycle();
        checkAll();

        // Level saturates at 15 and the laser period at its floor.
        curMode = 1; curAlive = 8'h00; idleCycle();
        for (int i = 0; i < 16; i++) runClear(1'b1);
        checkOutput("level_sat", 32'(level), 15);
        idleCycle();
        checkOutput("shoot_floor", 32'(shoot_timer), 100);

        // Reset in the middle of a clear aborts it without a respawn pulse.
        tickCycle(); idleCycle(); tickCycle();
        applyStimulus(1'b1, 1'b1, 10'd7, 10'd3, curAlive, curEdge);
        checkOutput("rst_no_pulse", 32'(alien_rst), 0);
        checkAll();

        // Randomized play against the model.
        begin
            bit [7:0] aliveBase = 8'hFF;
            for (int i = 0; i < 6000; i++) begin
                bit r, m, t;
                bit [9:0] x, y;
                bit [7:0] e;
                if (i % 40 == 0) begin
                    case ($urandom_range(0, 3))
                        0: aliveBase = 8'hFF;
                        1: aliveBase = 8'h00;
                        default: aliveBase = 8'($urandom);
                    endcase
                end
                r = ($urandom_range(0, 499) == 0);
                m = ($urandom_range(0, 149) != 0);
                t = ($urandom_range(0, 2) == 0);
                x = t ? 10'd0 : 10'($urandom_range(1, 639));
                y = t ? 10'd0 : 10'($urandom_range(0, 479));
                e = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
                applyStimulus(r, m, x, y, aliveBase, e);
                checkAll();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
